// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : rom_loader
// Purpose  : Boot loader that writes a checksummed byte-stream image into the
//            instruction ROM and holds the CPU in reset until it verifies.
// Revision : 1.0 - initial release
// ============================================================================
module rom_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              async_rst,
    input  logic              clk_en,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CNT_LO  = 3'd1;
    localparam logic [2:0] S_CNT_HI  = 3'd2;
    localparam logic [2:0] S_DATA_HI = 3'd3;
    localparam logic [2:0] S_DATA_LO = 3'd4;
    localparam logic [2:0] S_CHECK   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    localparam logic [16:0]     C_MAX_WORDS = 17'd1 << ADDR_W;
    localparam logic [ADDR_W:0] C_ONE       = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state_q,     state_d;
    logic [7:0]        cnt_lo_q,    cnt_lo_d;
    logic [ADDR_W:0]   count_q,     count_d;
    logic [ADDR_W:0]   index_q,     index_d;
    logic [7:0]        sum_q,       sum_d;
    logic [7:0]        hi_q,        hi_d;
    logic              rom_we_q,    rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q,  rom_addr_d;
    logic [15:0]       rom_wdata_q, rom_wdata_d;

    logic              w_accept;
    logic [15:0]       w_count;
    logic              w_bad_count;
    logic              w_last_word;

    always_comb begin
        rx_ready = 1'b0;
        if (clk_en) begin
            case (state_q)
                S_CNT_LO, S_CNT_HI, S_DATA_HI, S_DATA_LO, S_CHECK: rx_ready = 1'b1;
                default:                                           rx_ready = 1'b0;
            endcase
        end
    end

    assign w_accept    = rx_valid && rx_ready;
    assign w_count     = {rx_data, cnt_lo_q};
    assign w_bad_count = (w_count == 16'd0) || ({1'b0, w_count} > C_MAX_WORDS);
    assign w_last_word = (index_q == (count_q - C_ONE));

    always_comb begin
        state_d     = state_q;
        cnt_lo_d    = cnt_lo_q;
        count_d     = count_q;
        index_d     = index_q;
        sum_d       = sum_q;
        hi_d        = hi_q;
        rom_we_d    = rom_we_q;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;

        // rom_we only retires on an enabled edge so the ROM sees one write
        if (clk_en) begin
            rom_we_d = 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) state_d = S_CNT_LO;
                end
                S_CNT_LO: begin
                    if (w_accept) begin
                        cnt_lo_d = rx_data;
                        state_d  = S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (w_accept) begin
                        if (w_bad_count) begin
                            state_d = S_ERROR;
                        end else begin
                            count_d = w_count[ADDR_W:0];
                            index_d = '0;
                            sum_d   = '0;
                            state_d = S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (w_accept) begin
                        hi_d    = rx_data;
                        sum_d   = sum_q + rx_data;
                        state_d = S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (w_accept) begin
                        sum_d       = sum_q + rx_data;
                        rom_we_d    = 1'b1;
                        rom_addr_d  = index_q[ADDR_W-1:0];
                        rom_wdata_d = {hi_q, rx_data};
                        if (w_last_word) begin
                            state_d = S_CHECK;
                        end else begin
                            index_d = index_q + C_ONE;
                            state_d = S_DATA_HI;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_accept) state_d = (rx_data == sum_q) ? S_DONE : S_ERROR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q     <= S_IDLE;
            cnt_lo_q    <= '0;
            count_q     <= '0;
            index_q     <= '0;
            sum_q       <= '0;
            hi_q        <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_lo_q    <= cnt_lo_d;
            count_q     <= count_d;
            index_q     <= index_d;
            sum_q       <= sum_d;
            hi_q        <= hi_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
        end
    end

    assign rom_we    = rom_we_q;
    assign rom_addr  = rom_addr_q;
    assign rom_wdata = rom_wdata_q;
    assign cpu_hold  = (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign error     = (state_q == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_loader
// Purpose  : Directed self-checking bench for rom_loader with a stream-level
//            reference model of expected ROM writes and final status.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        async_rst;
    logic        clk_en;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rom_we;
    logic [9:0]  rom_addr;
    logic [15:0] rom_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    rom_loader #(.ADDR_W(10)) dut (
        .clk       (clk),
        .async_rst (async_rst),
        .clk_en    (clk_en),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    bit          stall = 1'b0;
    logic [25:0] exp_q[$];
    logic [7:0]  stream[$];
    int          wr_count = 0;
    int          wr_base  = 0;
    logic [9:0]  last_addr = '0;
    logic [15:0] last_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Enable pattern: always on unless the stall phase randomises it
    initial begin
        clk_en = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            clk_en = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Per-cycle compare against the expected write list and status invariants
    initial begin
        bit          prev_we = 1'b0;
        bit          prev_en = 1'b0;
        bit          last_en_we = 1'b0;
        logic [25:0] e;
        forever begin
            @(negedge clk);
            if (async_rst) begin
                prev_we    = 1'b0;
                prev_en    = 1'b0;
                last_en_we = 1'b0;
            end else begin
                check("hold_is_not_done", cpu_hold, !done);
                check("done_error_exclusive", done & error, 1'b0);
                if (!clk_en) check("ready_low_when_disabled", rx_ready, 1'b0);
                if (prev_we && !prev_en) check("we_held_when_disabled", rom_we, 1'b1);
                if (clk_en) begin
                    if (rom_we) begin
                        check("we_one_enabled_cycle", last_en_we, 1'b0);
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_write: addr %0h data %0h with none expected",
                                     rom_addr, rom_wdata);
                        end else begin
                            e = exp_q.pop_front();
                            check("wr_addr", rom_addr, e[25:16]);
                            check("wr_data", rom_wdata, e[15:0]);
                        end
                        wr_count++;
                        last_addr = rom_addr;
                        last_data = rom_wdata;
                    end
                    last_en_we = rom_we;
                end
                prev_we = rom_we;
                prev_en = clk_en;
            end
        end
    end

    // All stimulus tasks start and end at posedge + 1
    task automatic pulse_start();
        bit got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            start    = 1'b1;
            rx_valid = 1'b1;
            rx_data  = 8'hEE;
            @(negedge clk);
            got = clk_en;
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        rx_valid = 1'b0;
        if (!got) timeout("start_pulse");
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            rx_data  = b;
            rx_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            got = rx_valid && rx_ready;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (!got) timeout("send_byte");
    endtask

    // Stream-level model: parse count, words and checksum from the byte list
    task automatic run_load(input string name);
        int         n;
        int         nsend;
        logic [7:0] sum;
        bit         exp_done;
        logic [9:0] a;
        n       = int'({stream[1], stream[0]});
        wr_base = wr_count;
        if (n == 0 || n > 1024) begin
            nsend    = 2;
            exp_done = 1'b0;
        end else begin
            sum = 8'h00;
            for (int i = 0; i < n; i++) begin
                a = i[9:0];
                exp_q.push_back({a, stream[2 + 2 * i], stream[3 + 2 * i]});
                sum = sum + stream[2 + 2 * i] + stream[3 + 2 * i];
            end
            nsend    = 2 * n + 3;
            exp_done = (stream[2 + 2 * n] == sum);
        end
        pulse_start();
        for (int k = 0; k < nsend; k++) send_byte(stream[k]);
        check({name, "_done"}, done, exp_done);
        check({name, "_error"}, error, !exp_done);
        check({name, "_cpu_hold"}, cpu_hold, !exp_done);
        check({name, "_pending_writes"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        async_rst = 1'b1;
        start     = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_hold", cpu_hold, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_rom_we", rom_we, 1'b0);
        check("rst_rom_addr", rom_addr, 10'h000);
        check("rst_rom_wdata", rom_wdata, 16'h0000);
        check("rst_rx_ready", rx_ready, 1'b0);
        @(negedge clk);
        async_rst = 1'b0;
        @(posedge clk);
        #1;

        stream = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h46};
        run_load("minimal");
        check("minimal_wr_count", wr_count - wr_base, 1);
        check("minimal_addr", last_addr, 10'h000);
        check("minimal_data", last_data, 16'h1234);
        check("minimal_done_lit", done, 1'b1);

        stream = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h47};
        run_load("cks_bad");
        check("cks_bad_wr_count", wr_count - wr_base, 1);
        check("cks_bad_error_lit", error, 1'b1);

        stream = '{8'h00, 8'h00};
        run_load("count_zero");
        check("count_zero_no_write", wr_count - wr_base, 0);
        stream = '{8'h01, 8'h04};
        run_load("count_1025");
        check("count_1025_no_write", wr_count - wr_base, 0);
        check("count_1025_error_lit", error, 1'b1);

        stream = '{8'h00, 8'h04};
        for (int i = 0; i < 1024; i++) begin
            stream.push_back(8'(i >> 8));
            stream.push_back(8'(i & 255));
        end
        stream.push_back(8'h00);
        run_load("full");
        check("full_wr_count", wr_count - wr_base, 1024);
        check("full_last_addr", last_addr, 10'h3FF);
        check("full_last_data", last_data, 16'h03FF);
        check("full_done_lit", done, 1'b1);

        stream = '{8'h03, 8'h00, 8'hAB, 8'hCD, 8'h12, 8'h34, 8'hFF, 8'h01, 8'hBE};
        run_load("three");
        check("three_wr_count", wr_count - wr_base, 3);
        stall = 1'b1;
        run_load("three_stall");
        check("three_stall_wr_count", wr_count - wr_base, 3);
        check("three_stall_last", last_data, 16'hFF01);
        stall = 1'b0;
        @(posedge clk);
        #1;

        // Abort after the first data word, then reload and restart
        exp_q.push_back({10'h000, 16'hABCD});
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAB);
        send_byte(8'hCD);
        @(negedge clk);
        #2;
        async_rst = 1'b1;
        #1;
        check("midrst_rom_we", rom_we, 1'b0);
        check("midrst_cpu_hold", cpu_hold, 1'b1);
        check("midrst_done", done, 1'b0);
        check("midrst_rx_ready", rx_ready, 1'b0);
        check("midrst_rom_wdata", rom_wdata, 16'h0000);
        check("midrst_seen_write", exp_q.size(), 0);
        @(negedge clk);
        async_rst = 1'b0;
        @(posedge clk);
        #1;

        stream = '{8'h01, 8'h00, 8'h12, 8'h34, 8'h46};
        run_load("reload");
        check("reload_hold_low", cpu_hold, 1'b0);
        start = 1'b1;
        @(negedge clk);
        check("restart_done_before_edge", done, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_cpu_hold", cpu_hold, 1'b1);
        check("restart_done", done, 1'b0);
        check("restart_error", error, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rom_loader.md
# rom_loader

Boot-time program loader that receives a byte stream and writes it into the 1024×16 instruction ROM through the ROM's write port. The CPU is held in reset until a complete, checksum-verified image has been written. It sits beside the CPU in the top level: it drives the CPU's `sync_rst` through `cpu_hold` and owns the ROM write port. The CPU owns only the ROM read port.

## Interface
- `ADDR_W`, default 10: ROM address width. The maximum word count is 2^ADDR_W = 1024.
- `clk` input 1: system clock.
- `async_rst` input 1: asynchronous, active-high reset.
- `clk_en` input 1: global clock enable. State, counters and outputs change only on cycles where `clk_en`=1.
- `start` input 1: begins a load. Sampled in IDLE, DONE and ERROR.
- `rx_data` input 8: incoming byte.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_ready` output 1: the loader accepts a byte this cycle. It is combinational: `clk_en` AND state ∈ {CNT_LO, CNT_HI, DATA_HI, DATA_LO, CHECK}.
- `rom_we` output 1: ROM write strobe.
- `rom_addr` output ADDR_W: ROM write address.
- `rom_wdata` output 16: ROM write data.
- `cpu_hold` output 1: drives the CPU's `sync_rst`.
- `done` output 1: a verified image is loaded.
- `error` output 1: the load was aborted.

## Operation
- A byte is accepted when `rx_valid` and `rx_ready` are both 1.
- Stream format, in order:
  - count low byte, then count high byte (16-bit word count N);
  - N words, each sent high byte first;
  - one checksum byte.
- Checksum rule: the checksum byte equals the mod-256 sum of all 2N data bytes. Count bytes are excluded.
- States:
  - IDLE: `start` → CNT_LO.
  - CNT_LO: accept a byte → CNT_HI.
  - CNT_HI: accept a byte. If N=0 or N>1024 → ERROR; otherwise → DATA_HI, with the word index cleared to 0 and the sum cleared to 0.
  - DATA_HI: accept a byte, latch it as the high byte → DATA_LO.
  - DATA_LO: accept a byte and issue the write of {hi, lo} to address = index. If index = N−1 → CHECK; otherwise index+1 → DATA_HI.
  - CHECK: accept a byte. If it equals the sum → DONE; otherwise → ERROR.
  - DONE and ERROR: `start` → CNT_LO and clears `done`/`error`.
- `start` in any other state is ignored.
- The sum is 8 bits wide and wraps. The index is ADDR_W+1 bits wide, so N=1024 is representable and the last write goes to address 1023.
- Output values by state:
  - `cpu_hold` = 1 in every state except DONE.
  - `done` = 1 only in DONE.
  - `error` = 1 only in ERROR.
- ERROR does not undo writes already made. ROM contents are undefined until DONE.
- Reset values: state IDLE, `cpu_hold`=1, `done`=0, `error`=0, `rom_we`=0, `rom_addr`=0, `rom_wdata`=0. `rx_ready` is 0 because the state is IDLE. Index and sum are cleared to 0.
- Reset asserted mid-load returns immediately to IDLE with the outputs above. Any partially written image is abandoned.

## Timing
- `rom_we`, `rom_addr` and `rom_wdata` are registered. They are presented on the first `clk_en` cycle after the low byte is accepted.
- `rom_we` stays high for exactly one `clk_en`-qualified cycle. It holds its value across `clk_en`=0 cycles so that the ROM, which writes on `clk_en`, sees exactly one write.
- `rom_addr` and `rom_wdata` hold their values until the next write.
- Sustained throughput is one byte per enabled cycle when `rx_valid` stays high, so one word takes 2 enabled cycles.
- Load latency is 2N+3 accepted bytes from leaving IDLE to entering DONE.
- `cpu_hold` falls on the enabled edge that enters DONE. This edge is never earlier than the final `rom_we` cycle: the last write happens in the same cycle as or before the checksum byte is accepted, and DONE is entered only after that byte.
- With `clk_en`=0: no state change, `rx_ready`=0, and all registers hold.
- `start` and `rx_valid` asserted together in IDLE: only `start` is acted on. The byte is not consumed, because `rx_ready`=0 in IDLE.

## Test plan
- **Minimal load.** Reset, then `start`, then bytes 01 00 12 34 46. Required: one write with `rom_addr`=0 and `rom_wdata`=0x1234. Then `done`=1, `cpu_hold`=0, `error`=0.
- **Checksum mismatch.** Same stream with the checksum byte changed to 47. Required: the write still occurs, then `error`=1, `cpu_hold`=1, `done`=0.
- **Bad count.** Count 00 00, and separately count 01 04 (N=1025). Required: ERROR immediately after the count high byte is accepted, with no `rom_we` pulse.
- **Full ROM.** N=1024 (count bytes 00 04) with word i = i. Required: 1024 writes at addresses 0..1023 with matching data, checksum accepted, DONE reached, no address wrap past 1023.
- **Backpressure and enable.** Toggle `rx_valid` and `clk_en` randomly during a 3-word load. Required: the same writes and final state as the unstalled run, and each `rom_we` lasts exactly one enabled cycle.
- **Reset and restart.** Assert `async_rst` after 2 data bytes. Required: immediately IDLE, `cpu_hold`=1, `rom_we`=0. Then run a complete load. Afterwards pulse `start` in DONE. Required: `cpu_hold` rises and `done` clears on the next enabled edge.
